// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared encodings for the CoreI2C APB arbiter.
// The REC_* states are only present when I2C_ARB_STOP_RECOVERY_EN is defined.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GNT0       = 3'd1,
    ST_GNT1       = 3'd2
`ifdef I2C_ARB_STOP_RECOVERY_EN
    ,
    ST_REC_SETUP  = 3'd3,
    ST_REC_ACCESS = 3'd4
`endif
  } arb_state_t;

  // CoreI2C register offsets
  localparam logic [8:0] REG_CTRL  = 9'h00;
  localparam logic [8:0] REG_STAT  = 9'h04;
  localparam logic [8:0] REG_DATA  = 9'h08;
  localparam logic [8:0] REG_ADDR0 = 9'h0C;
  localparam logic [8:0] REG_SMB   = 9'h10;
  localparam logic [8:0] REG_ADDR1 = 9'h1C;

  // CTRL value that clears STA and sets STO
  localparam logic [7:0] CTRL_STOP = 8'h50;

  // owner codes
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;
  localparam logic [1:0] OWN_REC  = 2'b11;

endpackage

// File: rtl/i2c_arb_watchdog.sv
// i2c_arb_watchdog: saturating grant-age counter. Clear has priority over
// enable; expire stays high once the limit is reached until cleared.
module i2c_arb_watchdog #(
  parameter int              TO_W  = 16,
  parameter logic [TO_W-1:0] LIMIT = '1
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TO_W-1:0] r_cnt;

  // count enabled cycles, hold at all-ones instead of wrapping
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt >= LIMIT);

endmodule

// File: rtl/i2c_apb_arbiter.sv
// i2c_apb_arbiter: round-robin owner of the CoreI2C APB port for two masters.
// A grant is locked from req rise to req fall (START..STOP), a watchdog revokes
// a grant that sees no completed transfer for TIMEOUT_CYC cycles.
// Optional: I2C_ARB_STOP_RECOVERY_EN makes the arbiter write CTRL=STOP after a
// revoke so the I2C bus is released.
//
// state         | meaning
// ST_IDLE       | no owner, arbitrate between requests
// ST_GNT0       | master 0 owns the slave port
// ST_GNT1       | master 1 owns the slave port
// ST_REC_SETUP  | arbiter STOP write, APB setup phase
// ST_REC_ACCESS | arbiter STOP write, APB access phase until PREADY
module i2c_apb_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       m0_req,
  output logic       m0_gnt,
  input  logic       m0_psel,
  input  logic       m0_penable,
  input  logic       m0_pwrite,
  input  logic [8:0] m0_paddr,
  input  logic [7:0] m0_pwdata,
  output logic [7:0] m0_prdata,
  output logic       m0_pready,
  output logic       m0_pslverr,
  input  logic       m1_req,
  output logic       m1_gnt,
  input  logic       m1_psel,
  input  logic       m1_penable,
  input  logic       m1_pwrite,
  input  logic [8:0] m1_paddr,
  input  logic [7:0] m1_pwdata,
  output logic [7:0] m1_prdata,
  output logic       m1_pready,
  output logic       m1_pslverr,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [8:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  output logic [1:0] owner,
  output logic       timeout
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic       w_in_gnt;
  logic       w_own_req;
  logic       w_own_psel;
  logic       w_own_penable;
  logic       w_done;
  logic       w_expire;
  logic       w_timeout;

  assign w_in_gnt      = (r_state == ST_GNT0) || (r_state == ST_GNT1);
  assign w_own_req     = (r_state == ST_GNT1) ? m1_req     : m0_req;
  assign w_own_psel    = (r_state == ST_GNT1) ? m1_psel    : m0_psel;
  assign w_own_penable = (r_state == ST_GNT1) ? m1_penable : m0_penable;
  assign w_done        = w_in_gnt && w_own_psel && w_own_penable && PREADY;
  // an open transfer defers the revoke; completion clears the age instead
  assign w_timeout     = w_in_gnt && w_expire && !w_own_psel;
  assign timeout       = w_timeout;

  i2c_arb_watchdog #(
    .TO_W  (TO_W),
    .LIMIT (TO_W'(TIMEOUT_CYC - 1))
  ) u_wdog (
    .PCLK     (PCLK),
    .PRESETN  (PRESETN),
    .i_clr    (!w_in_gnt || w_done),
    .i_en     (w_in_gnt),
    .o_expire (w_expire)
  );

  // state register and round-robin pointer (last granted master)
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_GNT0)) begin
        r_last <= 1'b0;
      end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_GNT1)) begin
        r_last <= 1'b1;
      end
    end
  end

  // next-state: arbitrate in IDLE, hold the lock, release or revoke
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_req && (!m1_req || r_last)) begin
          w_state_nxt = ST_GNT0;
        end else if (m1_req) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (w_timeout) begin
`ifdef I2C_ARB_STOP_RECOVERY_EN
          w_state_nxt = ST_REC_SETUP;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else if (!w_own_req && (!w_own_psel || w_done)) begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef I2C_ARB_STOP_RECOVERY_EN
      ST_REC_SETUP: begin
        w_state_nxt = ST_REC_ACCESS;
      end
      ST_REC_ACCESS: begin
        if (PREADY) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // outputs: grant/owner decode, slave mux and return path from the state
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    owner      = OWN_NONE;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = '0;
    PWDATA     = '0;
    m0_prdata  = '0;
    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m1_prdata  = '0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;
    case (r_state)
      ST_GNT0: begin
        m0_gnt     = 1'b1;
        owner      = OWN_M0;
        PSEL       = m0_psel;
        PENABLE    = m0_penable;
        PWRITE     = m0_pwrite;
        PADDR      = m0_paddr;
        PWDATA     = m0_pwdata;
        m0_prdata  = PRDATA;
        m0_pready  = PREADY;
        m0_pslverr = PSLVERR;
      end
      ST_GNT1: begin
        m1_gnt     = 1'b1;
        owner      = OWN_M1;
        PSEL       = m1_psel;
        PENABLE    = m1_penable;
        PWRITE     = m1_pwrite;
        PADDR      = m1_paddr;
        PWDATA     = m1_pwdata;
        m1_prdata  = PRDATA;
        m1_pready  = PREADY;
        m1_pslverr = PSLVERR;
      end
`ifdef I2C_ARB_STOP_RECOVERY_EN
      ST_REC_SETUP, ST_REC_ACCESS: begin
        owner   = OWN_REC;
        PSEL    = 1'b1;
        PENABLE = (r_state == ST_REC_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = REG_CTRL;
        PWDATA  = CTRL_STOP;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// tb_i2c_apb_arbiter: random two-master traffic against an owner-level
// reference model; expected outputs are queued per cycle and a separate
// monitor compares them with the DUT.
module tb_i2c_apb_arbiter;

  localparam int TCYC = 16;
  localparam int NCYC = 3000;

  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic       m0_req = 1'b0, m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
  logic [8:0] m0_paddr = '0;
  logic [7:0] m0_pwdata = '0;
  logic       m1_req = 1'b0, m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
  logic [8:0] m1_paddr = '0;
  logic [7:0] m1_pwdata = '0;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0, PSLVERR = 1'b0;
  logic       m0_gnt, m0_pready, m0_pslverr, m1_gnt, m1_pready, m1_pslverr;
  logic [7:0] m0_prdata, m1_prdata, PWDATA;
  logic       PSEL, PENABLE, PWRITE, timeout;
  logic [8:0] PADDR;
  logic [1:0] owner;

  always #5 PCLK = ~PCLK;

  i2c_apb_arbiter #(.TIMEOUT_CYC(TCYC), .TO_W(16)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_psel(m0_psel), .m0_penable(m0_penable),
    .m0_pwrite(m0_pwrite), .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_psel(m1_psel), .m1_penable(m1_penable),
    .m1_pwrite(m1_pwrite), .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .owner(owner), .timeout(timeout)
  );

  typedef struct packed {
    logic       gnt0;
    logic       gnt1;
    logic [1:0] own;
    logic       to;
    logic       psel;
    logic       pen;
    logic       pwr;
    logic [8:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] rd0;
    logic       rdy0;
    logic       err0;
    logic [7:0] rd1;
    logic       rdy1;
    logic       err1;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // reference model: who owns the port, how long since grant/completion
  int md_own;    // 0 none, 1 m0, 2 m1, 3 arbiter STOP write
  int md_last;   // last master granted
  int md_age;
  int md_phase;  // STOP write: 0 setup, 1 access
  bit md_done[2];

  // per-master stimulus state
  bit         s_req[2], s_psel[2], s_pen[2], s_pwr[2], s_quiet[2];
  logic [8:0] s_paddr[2];
  logic [7:0] s_pwdata[2];
  logic [8:0] reg_tab[6] = '{9'h00, 9'h04, 9'h08, 9'h0C, 9'h10, 9'h1C};

  task automatic md_reset();
    md_own = 0; md_last = 1; md_age = 0; md_phase = 0;
    md_done[0] = 1'b0; md_done[1] = 1'b0;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int   w;
    o = '0;
    o.own  = 2'(md_own);
    o.gnt0 = (md_own == 1);
    o.gnt1 = (md_own == 2);
    if (md_own == 1 || md_own == 2) begin
      w = md_own - 1;
      o.psel   = s_psel[w];
      o.pen    = s_pen[w];
      o.pwr    = s_pwr[w];
      o.paddr  = s_paddr[w];
      o.pwdata = s_pwdata[w];
      o.to     = (md_age >= TCYC - 1) && !s_psel[w];
      if (w == 0) begin
        o.rd0 = PRDATA; o.rdy0 = PREADY; o.err0 = PSLVERR;
      end else begin
        o.rd1 = PRDATA; o.rdy1 = PREADY; o.err1 = PSLVERR;
      end
    end else if (md_own == 3) begin
      o.psel   = 1'b1;
      o.pen    = (md_phase == 1);
      o.pwr    = 1'b1;
      o.paddr  = 9'h000;
      o.pwdata = 8'h50;
    end
    return o;
  endfunction

  task automatic model_step();
    int w;
    bit done, tmo;
    md_done[0] = 1'b0; md_done[1] = 1'b0;
    if (!PRESETN) begin
      md_reset();
      return;
    end
    case (md_own)
      0: begin
        if (s_req[0] && s_req[1]) w = (md_last == 0) ? 1 : 0;
        else if (s_req[0])        w = 0;
        else if (s_req[1])        w = 1;
        else                      w = -1;
        if (w >= 0) begin
          md_own = w + 1; md_last = w; md_age = 0;
        end
      end
      1, 2: begin
        w    = md_own - 1;
        done = s_psel[w] && s_pen[w] && PREADY;
        tmo  = (md_age >= TCYC - 1) && !s_psel[w];
        md_done[w] = done;
        md_age = done ? 0 : ((md_age < 65535) ? md_age + 1 : md_age);
        if (tmo) begin
`ifdef I2C_ARB_STOP_RECOVERY_EN
          md_own = 3; md_phase = 0;
`else
          md_own = 0;
`endif
        end else if (!s_req[w] && (!s_psel[w] || done)) begin
          md_own = 0;
        end
      end
      default: begin
        if (md_phase == 0)  md_phase = 1;
        else if (PREADY)    md_own = 0;
      end
    endcase
  endtask

  task automatic gen_stim(input int cyc);
    PREADY  = ($urandom_range(9) < 6);
    PRDATA  = 8'($urandom);
    PSLVERR = ($urandom_range(7) == 0);
    for (int w = 0; w < 2; w++) begin
      if (cyc % 40 == 0) s_quiet[w] = 1'($urandom_range(1));
      if (cyc < 60) begin
        // both request from reset with no traffic: tie, timeouts, handover
        s_quiet[w] = 1'b1;
        s_req[w]   = 1'b1;
      end else if ($urandom_range(s_quiet[w] ? 39 : 15) == 0) begin
        s_req[w] = !s_req[w];
      end
      if (s_psel[w] && !s_pen[w]) begin
        s_pen[w] = 1'b1;
      end else if (s_psel[w] && s_pen[w]) begin
        if (md_done[w]) begin
          s_psel[w] = 1'b0; s_pen[w] = 1'b0;
        end else if (md_own != w + 1 && $urandom_range(7) == 0) begin
          s_psel[w] = 1'b0; s_pen[w] = 1'b0;
        end
      end else if (!s_quiet[w] && $urandom_range(3) == 0) begin
        s_psel[w]   = 1'b1;
        s_pen[w]    = 1'b0;
        s_pwr[w]    = 1'($urandom_range(1));
        s_paddr[w]  = reg_tab[$urandom_range(5)];
        s_pwdata[w] = 8'($urandom);
      end
    end
    m0_req = s_req[0]; m0_psel = s_psel[0]; m0_penable = s_pen[0];
    m0_pwrite = s_pwr[0]; m0_paddr = s_paddr[0]; m0_pwdata = s_pwdata[0];
    m1_req = s_req[1]; m1_psel = s_psel[1]; m1_penable = s_pen[1];
    m1_pwrite = s_pwr[1]; m1_paddr = s_paddr[1]; m1_pwdata = s_pwdata[1];
  endtask

  // driver: new inputs on each falling edge, expected outputs queued
  initial begin
    md_reset();
    for (int w = 0; w < 2; w++) begin
      s_req[w] = 1'b0; s_psel[w] = 1'b0; s_pen[w] = 1'b0; s_pwr[w] = 1'b0;
      s_quiet[w] = 1'b1; s_paddr[w] = '0; s_pwdata[w] = '0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge PCLK);
      PRESETN = !((cyc < 3) || (cyc >= 1500 && cyc < 1502));
      gen_stim(cyc);
      if (!PRESETN) md_reset();
      exp_q.push_back(model_out());
      model_step();
    end
    @(negedge PCLK);
    #4;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL leftover_expectations: got %0d entries, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // monitor: compare the DUT's outputs once per cycle, mid-cycle
  initial begin
    obs_t e, a;
    int   mcyc;
    mcyc = 0;
    forever begin
      @(negedge PCLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.gnt0 = m0_gnt;     a.gnt1 = m1_gnt;     a.own = owner;    a.to = timeout;
        a.psel = PSEL;       a.pen = PENABLE;     a.pwr = PWRITE;
        a.paddr = PADDR;     a.pwdata = PWDATA;
        a.rd0 = m0_prdata;   a.rdy0 = m0_pready;  a.err0 = m0_pslverr;
        a.rd1 = m1_prdata;   a.rdy1 = m1_pready;  a.err1 = m1_pslverr;
        n_total++;
        if (a === e) begin
          n_pass++;
        end else begin
          $display("FAIL cycle%0d outputs: got gnt=%b%b own=%b to=%b slv=%b%b%b/%h/%h ret0=%h/%b%b ret1=%h/%b%b, required gnt=%b%b own=%b to=%b slv=%b%b%b/%h/%h ret0=%h/%b%b ret1=%h/%b%b",
                   mcyc, a.gnt0, a.gnt1, a.own, a.to, a.psel, a.pen, a.pwr, a.paddr, a.pwdata,
                   a.rd0, a.rdy0, a.err0, a.rd1, a.rdy1, a.err1,
                   e.gnt0, e.gnt1, e.own, e.to, e.psel, e.pen, e.pwr, e.paddr, e.pwdata,
                   e.rd0, e.rdy0, e.err0, e.rd1, e.rdy1, e.err1);
        end
        mcyc++;
      end
    end
  end

endmodule
